// File: rtl/dmem_line_ctrl.sv
// Line-granular backing-store controller behind data_cache: fixed-latency refills and writebacks,
// with a dirty-miss writeback serialised ahead of its refill.
module dmem_line_ctrl #(
    parameter int unsigned LATENCY   = 5,
    parameter int unsigned DEPTH     = 256,
    parameter string       INIT_FILE = ""
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqD_mem,
    input  logic [25:0]  reqAddrD_mem,
    input  logic         reqD_cache_write,
    input  logic [127:0] data_to_mem,
    input  logic [25:0]  reqAddrD_write_mem,
    output logic [127:0] data_from_mem,
    output logic         read_ready_from_mem,
    output logic         written_data_ack,
    output logic         mem_busy
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WB_WAIT, RD_WAIT} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           rd_armed;
    logic           wr_armed;
    logic           pend_rd;
    logic [IW-1:0]  widx;
    logic [IW-1:0]  ridx;
    logic [127:0]   wdata;
    logic [127:0]   store [DEPTH];
    logic           store_we;
    logic           rd_go;
    logic           wr_go;
    logic           cnt_done;

    // Upper line-address bits alias onto the store and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{reqAddrD_mem[25:IW], reqAddrD_write_mem[25:IW]};

    assign rd_go    = reqD_mem & rd_armed;
    assign wr_go    = reqD_cache_write & wr_armed;
    assign cnt_done = (cnt == CW'(LATENCY));
    assign store_we = !reset && (state == WB_WAIT) && cnt_done;

    // Power-up image of the backing store; reset never touches it.
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) store[i] = '0;
    end

    always_ff @(posedge clk) begin
        if (store_we) store[widx] <= wdata;
    end

    always_ff @(posedge clk) begin
        read_ready_from_mem <= 1'b0;
        written_data_ack    <= 1'b0;
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            data_from_mem <= '0;
            mem_busy      <= 1'b0;
            rd_armed      <= 1'b1;
            wr_armed      <= 1'b1;
            pend_rd       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_go) begin
                        widx     <= reqAddrD_write_mem[IW-1:0];
                        wdata    <= data_to_mem;
                        pend_rd  <= rd_go;
                        ridx     <= reqAddrD_mem[IW-1:0];
                        cnt      <= CW'(1);
                        state    <= WB_WAIT;
                        mem_busy <= 1'b1;
                    end else if (rd_go) begin
                        pend_rd  <= 1'b0;
                        ridx     <= reqAddrD_mem[IW-1:0];
                        cnt      <= CW'(1);
                        state    <= RD_WAIT;
                        mem_busy <= 1'b1;
                    end
                end
                WB_WAIT: begin
                    if (cnt_done) begin
                        written_data_ack <= 1'b1;
                        wr_armed         <= 1'b0;
                        if (pend_rd) begin
                            cnt   <= CW'(1);
                            state <= RD_WAIT;
                        end else begin
                            cnt      <= '0;
                            state    <= IDLE;
                            mem_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RD_WAIT: begin
                    if (cnt_done) begin
                        // Same-line dirty miss: the writeback committed LATENCY edges earlier.
                        data_from_mem       <= store[ridx];
                        read_ready_from_mem <= 1'b1;
                        rd_armed            <= 1'b0;
                        cnt                 <= '0;
                        state               <= IDLE;
                        mem_busy            <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
            endcase
            // A dropped request re-arms its channel so a held level is serviced only once.
            if (!reqD_mem)         rd_armed <= 1'b1;
            if (!reqD_cache_write) wr_armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Self-checking bench for dmem_line_ctrl: refill data is scoreboarded against a reference line store.
module tb_dmem_line_ctrl;

    localparam int unsigned LAT   = 5;
    localparam int unsigned DEPTH = 256;

    logic         clk = 1'b0;
    logic         reset;
    logic         reqD_mem;
    logic [25:0]  reqAddrD_mem;
    logic         reqD_cache_write;
    logic [127:0] data_to_mem;
    logic [25:0]  reqAddrD_write_mem;
    logic [127:0] data_from_mem;
    logic         read_ready_from_mem;
    logic         written_data_ack;
    logic         mem_busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] model [DEPTH];
    logic [127:0] exp_q [$];

    dmem_line_ctrl #(.LATENCY(LAT), .DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clk                 (clk),
        .reset               (reset),
        .reqD_mem            (reqD_mem),
        .reqAddrD_mem        (reqAddrD_mem),
        .reqD_cache_write    (reqD_cache_write),
        .data_to_mem         (data_to_mem),
        .reqAddrD_write_mem  (reqAddrD_write_mem),
        .data_from_mem       (data_from_mem),
        .read_ready_from_mem (read_ready_from_mem),
        .written_data_ack    (written_data_ack),
        .mem_busy            (mem_busy)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [25:0] a);
        return int'(a) % int'(DEPTH);
    endfunction

    // Pops the scoreboard when a refill pulse is observed and compares the returned line.
    task automatic check_refill_data(input string name);
        logic [127:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: refill pulse with empty scoreboard, got %h", name, data_from_mem);
        end else begin
            e = exp_q.pop_front();
            if (data_from_mem !== e) begin
                errors++;
                $display("FAIL %s: data_from_mem got %h expected %h", name, data_from_mem, e);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqD_mem = 1'b0; reqAddrD_mem = '0;
        reqD_cache_write = 1'b0; data_to_mem = '0; reqAddrD_write_mem = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({read_ready_from_mem, written_data_ack, mem_busy} !== 3'b000 || data_from_mem !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready/ack/busy got %b data %h expected 000 and 0",
                     {read_ready_from_mem, written_data_ack, mem_busy}, data_from_mem);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", mem_busy);
        end
    endtask

    // Writeback held for hold cycles; exactly one ack, LAT edges after acceptance.
    task automatic test_writeback(input logic [25:0] a, input logic [127:0] d, input int hold);
        int ack_at = -1;
        int acks = 0;
        int busy_bad = 0;
        reqD_cache_write = 1'b1; reqAddrD_write_mem = a; data_to_mem = d;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (written_data_ack) begin
                acks++;
                if (ack_at < 0) ack_at = i;
            end
            if (i < int'(LAT) && mem_busy !== 1'b1) busy_bad++;
            if (i == int'(LAT) && mem_busy !== 1'b0) busy_bad++;
            // The cache may change the bus after acceptance.
            if (i == 0) data_to_mem = ~d;
        end
        reqD_cache_write = 1'b0;
        @(negedge clk);
        if (ack_at == int'(LAT)) model[idx(a)] = d;
        checks++;
        if (ack_at != int'(LAT)) begin
            errors++;
            $display("FAIL wb_ack_latency: ack at %0d expected %0d", ack_at, LAT);
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL wb_single_ack: %0d acks expected 1", acks);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL wb_busy: %0d bad busy samples expected 0", busy_bad);
        end
    endtask

    // Refill; returns negedge index (edges after acceptance) at which ready was seen.
    task automatic do_refill(input logic [25:0] a, input string name, output int lat);
        lat = -1;
        exp_q.push_back(model[idx(a)]);
        reqD_mem = 1'b1; reqAddrD_mem = a;
        for (int i = 0; i <= 4 * int'(LAT); i++) begin
            @(negedge clk);
            if (i == 0) reqAddrD_mem = ~a;
            if (read_ready_from_mem) begin
                lat = i;
                check_refill_data(name);
                break;
            end
        end
        reqD_mem = 1'b0;
        if (lat < 0) begin
            void'(exp_q.pop_front());
            checks++;
            errors++;
            $display("FAIL %s_timeout: no read_ready_from_mem within %0d cycles", name, 4 * LAT);
        end
    endtask

    task automatic test_refill(input logic [25:0] a, input string name);
        int lat;
        logic [127:0] held;
        do_refill(a, name, lat);
        held = data_from_mem;
        checks++;
        if (lat != int'(LAT)) begin
            errors++;
            $display("FAIL %s_latency: ready at %0d expected %0d", name, lat, LAT);
        end
        @(negedge clk);
        checks++;
        if (read_ready_from_mem !== 1'b0 || data_from_mem !== held) begin
            errors++;
            $display("FAIL %s_pulse_hold: ready %b data %h expected 0 and %h",
                     name, read_ready_from_mem, data_from_mem, held);
        end
    endtask

    task automatic test_combined(input logic [25:0] a, input logic [127:0] d);
        int ack_at = -1;
        int rdy_at = -1;
        int overlap = 0;
        exp_q.push_back(d);
        reqD_cache_write = 1'b1; reqAddrD_write_mem = a; data_to_mem = d;
        reqD_mem = 1'b1; reqAddrD_mem = a;
        for (int i = 0; i <= 4 * int'(LAT); i++) begin
            @(negedge clk);
            if (written_data_ack && read_ready_from_mem) overlap++;
            if (written_data_ack && ack_at < 0) ack_at = i;
            if (read_ready_from_mem) begin
                rdy_at = i;
                check_refill_data("combined_data");
                break;
            end
        end
        reqD_cache_write = 1'b0; reqD_mem = 1'b0;
        if (rdy_at < 0) void'(exp_q.pop_front());
        model[idx(a)] = d;
        @(negedge clk);
        checks++;
        if (ack_at != int'(LAT) || rdy_at != 2 * int'(LAT)) begin
            errors++;
            $display("FAIL combined_timing: ack %0d ready %0d expected %0d and %0d",
                     ack_at, rdy_at, LAT, 2 * LAT);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL combined_overlap: %0d overlapping pulses expected 0", overlap);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        do_refill(26'd4, "b2b_first", lat1);
        @(negedge clk);
        do_refill(26'd9, "b2b_second", lat2);
        // Gap between pulses: the one idle negedge plus the second refill's edges.
        checks++;
        if (lat1 != int'(LAT) || (lat2 + 2) < int'(LAT) + 1 || lat2 != int'(LAT)) begin
            errors++;
            $display("FAIL b2b_gap: lat1 %0d lat2 %0d gap %0d expected latencies %0d, gap >= %0d",
                     lat1, lat2, lat2 + 2, LAT, LAT + 1);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        reqD_cache_write = 1'b1; reqAddrD_write_mem = 26'd1; data_to_mem = 128'hDEAD_BEEF_0000_0001;
        repeat (3) @(negedge clk);
        reset = 1'b1; reqD_cache_write = 1'b0;
        @(negedge clk);
        checks++;
        if ({read_ready_from_mem, written_data_ack, mem_busy} !== 3'b000 || data_from_mem !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: ready/ack/busy got %b data %h expected 000 and 0",
                     {read_ready_from_mem, written_data_ack, mem_busy}, data_from_mem);
        end
        reset = 1'b0;
        for (int i = 0; i < 3 * int'(LAT); i++) begin
            @(negedge clk);
            if (written_data_ack || read_ready_from_mem) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL midreset_no_pulse: %0d pulses expected 0", acks);
        end
        test_refill(26'd1, "midreset_store");
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        test_reset();
        test_refill(26'd20, "zero_line");
        test_writeback(26'd3, {32{4'hA}}, 8);
        test_refill(26'd3, "refill_a");
        test_writeback(26'd7, 128'h1234, 20);
        test_refill(26'd7, "refill_wb7");
        test_combined(26'd2, 128'hD1D1_0000_FFFF_0000_1234_5678_9ABC_DEF0);
        test_writeback(26'd4, 128'h4444, 8);
        test_writeback(26'd9, 128'h9999_0000_0000_0009, 8);
        test_back_to_back();
        test_reset_mid();
        test_writeback(26'h105, 128'h0105_CAFE, 8);
        test_refill(26'h005, "alias");
        test_refill(26'h3FF_FF07, "alias_high");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
